// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake state reported by the memory model.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_access_timer.sv
// Saturating access-cycle counter; expired flags the last cycle an access may wait for the RAM.
module access_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // clr wins over en so the count restarts from zero on every new access
  always_ff @(posedge CLK) begin
    if (!nRST || clr) begin
      count <= '0;
    end else if (en && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data requests; data always wins,
// one access at a time, one-cycle hit pulses with registered load data.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    INSTR = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } arb_state_t;

  arb_state_t state;
  arb_state_t state_nxt;

  word_t addr_q;
  word_t store_q;
  logic  write_q;
  logic  in_access;
  logic  expired;
  logic  data_req;

  assign in_access = (state == DATA) || (state == INSTR);
  assign data_req  = dREN || dWEN;

  access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (!in_access),
    .en      (in_access),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (data_req) begin
          state_nxt = DATA;
        end else if (iREN) begin
          state_nxt = INSTR;
        end
      end
      DATA, INSTR: begin
        // ACCESS on the expiring cycle still completes the transfer
        if (ramstate == ACCESS) begin
          state_nxt = RESP;
        end else if ((ramstate == ERROR) || expired) begin
          state_nxt = ERR;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      write_q <= 1'b0;
      ihit    <= 1'b0;
      dhit    <= 1'b0;
      iload   <= '0;
      dload   <= '0;
      arb_err <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      if (state == IDLE) begin
        if (data_req) begin
          addr_q  <= daddr;
          store_q <= dstore;
          write_q <= dWEN;
        end else if (iREN) begin
          addr_q  <= iaddr;
          write_q <= 1'b0;
        end
      end
      if ((state == INSTR) && (ramstate == ACCESS)) begin
        ihit  <= 1'b1;
        iload <= ramload;
      end
      // a write completion leaves the previous read word in dload
      if ((state == DATA) && (ramstate == ACCESS)) begin
        dhit <= 1'b1;
        if (!write_q) begin
          dload <= ramload;
        end
      end
      if (in_access && (state_nxt == ERR)) begin
        arb_err <= 1'b1;
      end
    end
  end

  assign ramREN   = (state == INSTR) || ((state == DATA) && !write_q);
  assign ramWEN   = (state == DATA) && write_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, multi-cycle corner
// sequences (reset, timeout, RAM error, reset mid-access) and randomized transactions.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 8;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      ihit;
  logic      dhit;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      arb_err;

  int n_checks = 0;
  int n_pass   = 0;
  word_t m_dload = '0;

  typedef struct {
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] ds;
    int          busy;
    logic [31:0] rdata;
    logic        exp_dsel;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
    logic [31:0] exp_load;
  } txn_t;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .dhit     (dhit),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .arb_err  (arb_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  task automatic do_reset(input int ncyc);
    nRST = 1'b0;
    repeat (ncyc) tick();
    nRST = 1'b1;
    m_dload = '0;
  endtask

  // Reference rules: any data request wins, dWEN makes it a write, a write keeps old dload.
  function automatic txn_t predict(input txn_t t);
    txn_t r = t;
    r.exp_dsel  = t.dren | t.dwen;
    r.exp_wen   = t.dwen;
    r.exp_ren   = ~t.dwen;
    r.exp_addr  = r.exp_dsel ? t.da : t.ia;
    r.exp_store = t.ds;
    r.exp_load  = t.dwen ? m_dload : t.rdata;
    return r;
  endfunction

  // Starts in IDLE just after an edge; ends in IDLE just after an edge.
  task automatic run_txn(input txn_t t, input string tag);
    iREN = t.iren; dREN = t.dren; dWEN = t.dwen;
    iaddr = t.ia; daddr = t.da; dstore = t.ds;
    ramstate = BUSY; ramload = $urandom;
    tick();
    for (int k = 1; k <= t.busy + 1; k++) begin
      check({tag, " ramREN"}, 32'(ramREN), 32'(t.exp_ren));
      check({tag, " ramWEN"}, 32'(ramWEN), 32'(t.exp_wen));
      check({tag, " ramaddr"}, ramaddr, t.exp_addr);
      if (t.exp_wen) check({tag, " ramstore"}, ramstore, t.exp_store);
      check({tag, " early hit"}, {30'd0, ihit, dhit}, 32'd0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom;
      ramstate = (k == t.busy + 1) ? ACCESS : BUSY;
      ramload  = (k == t.busy + 1) ? t.rdata : $urandom;
      tick();
    end
    check({tag, " ihit"}, 32'(ihit), 32'(!t.exp_dsel));
    check({tag, " dhit"}, 32'(dhit), 32'(t.exp_dsel));
    if (t.exp_dsel) check({tag, " dload"}, dload, t.exp_load);
    else            check({tag, " iload"}, iload, t.exp_load);
    check({tag, " enables in resp"}, {30'd0, ramREN, ramWEN}, 32'd0);
    if (t.dren && !t.dwen) m_dload = t.rdata;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();
    check({tag, " single pulse"}, {30'd0, ihit, dhit}, 32'd0);
    check({tag, " arb_err"}, 32'(arb_err), 32'd0);
  endtask

  txn_t vec [6];
  txn_t rt;

  initial begin
    //           iren dren dwen ia           da           ds           busy rdata        dsel ren  wen  addr         store        load
    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h40,     32'h0,       32'h0,       0, 32'h8C220004, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,       32'h8C220004};
    vec[1] = '{1'b1, 1'b0, 1'b1, 32'h0,      32'h100,     32'hDEADBEEF, 0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0};
    vec[2] = '{1'b1, 1'b0, 1'b0, 32'h0,      32'h0,       32'h0,       1, 32'h00000013, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,       32'h00000013};
    vec[3] = '{1'b0, 1'b1, 1'b0, 32'h0,      32'h80,      32'h0,       3, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h80,  32'h0,       32'h12345678};
    vec[4] = '{1'b0, 1'b1, 1'b1, 32'h0,      32'h200,     32'hCAFEF00D, 2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 32'h12345678};
    vec[5] = '{1'b1, 1'b1, 1'b0, 32'h44,     32'h84,      32'h0,       0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h84,  32'h0,       32'hA5A5A5A5};

    idle_inputs();
    nRST = 1'b0;
    iREN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("reset ihit/dhit", {30'd0, ihit, dhit}, 32'd0);
      check("reset enables", {30'd0, ramREN, ramWEN}, 32'd0);
      check("reset arb_err", 32'(arb_err), 32'd0);
    end
    nRST = 1'b1;
    iREN = 1'b0;
    tick();
    check("idle enables", {30'd0, ramREN, ramWEN}, 32'd0);

    for (int i = 0; i < 6; i++) run_txn(vec[i], $sformatf("vec%0d", i));

    // RAM never answers: eight access cycles, then ERR with enables down
    dREN = 1'b1; daddr = 32'h0000_0400; ramstate = BUSY;
    tick();
    for (int k = 1; k <= TIMEOUT; k++) begin
      check("timeout ramREN held", 32'(ramREN), 32'd1);
      check("timeout arb_err low", 32'(arb_err), 32'd0);
      tick();
    end
    check("timeout arb_err", 32'(arb_err), 32'd1);
    check("timeout enables", {30'd0, ramREN, ramWEN}, 32'd0);
    iREN = 1'b1; ramstate = ACCESS;
    repeat (3) tick();
    check("err stays, no hits", {29'd0, arb_err, ihit, dhit}, 32'd4);
    check("err enables stay low", {30'd0, ramREN, ramWEN}, 32'd0);
    idle_inputs();
    do_reset(1);
    check("err cleared by reset", 32'(arb_err), 32'd0);

    // ERROR reported by RAM during a write
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h1; ramstate = BUSY;
    tick();
    check("error ramWEN", 32'(ramWEN), 32'd1);
    ramstate = ERROR;
    tick();
    check("error arb_err", 32'(arb_err), 32'd1);
    check("error enables", {30'd0, ramREN, ramWEN}, 32'd0);
    check("error no hit", {30'd0, ihit, dhit}, 32'd0);
    idle_inputs();
    do_reset(1);

    // reset in the middle of a BUSY data read
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick();
    tick();
    check("mid ramREN before reset", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    tick();
    check("mid reset enables", {30'd0, ramREN, ramWEN}, 32'd0);
    check("mid reset ramaddr", ramaddr, 32'd0);
    nRST = 1'b1; m_dload = '0;
    idle_inputs();
    tick();
    check("mid post-reset enables", {30'd0, ramREN, ramWEN}, 32'd0);
    rt = '{1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 1, 32'h0BADF00D,
           1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    run_txn(predict(rt), "post-reset instr");

    for (int i = 0; i < 40; i++) begin
      rt.iren  = $urandom_range(0, 1);
      rt.dren  = $urandom_range(0, 1);
      rt.dwen  = ($urandom_range(0, 3) == 0);
      rt.ia    = $urandom;
      rt.da    = $urandom;
      rt.ds    = $urandom;
      rt.busy  = $urandom_range(0, TIMEOUT - 2);
      rt.rdata = $urandom;
      if (!(rt.iren || rt.dren || rt.dwen)) begin
        tick();
        check("rand idle enables", {30'd0, ramREN, ramWEN}, 32'd0);
        check("rand idle hits", {30'd0, ihit, dhit}, 32'd0);
      end else begin
        run_txn(predict(rt), $sformatf("rand%0d", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
